// File: rtl/parity_arbiter_pkg.sv
// Shared types and default sizing for the parity arbiter.
package parity_arbiter_pkg;

  localparam int unsigned DEF_NUM_REQ = 4;
  localparam int unsigned DEF_DATA_W  = 8;
  localparam int unsigned TXN_W       = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_RESPOND = 2'd2
  } state_e;

endpackage

// File: rtl/parity_arbiter_parity_unit.sv
// Shared combinational parity unit: even parity bit (XOR-reduce) of one data word.
module parity_unit #(
  parameter int unsigned DATA_W = 8
) (
  input  logic [DATA_W-1:0] data_i,
  output logic              parity_o
);

  assign parity_o = ^data_i;

endmodule

// File: rtl/parity_arbiter.sv
// Round-robin arbiter: serves one requester at a time, returns the captured word
// and its parity through a registered response channel.
module parity_arbiter
  import parity_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEF_NUM_REQ,
  parameter int unsigned DATA_W  = DEF_DATA_W
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0]  rsp_id,
  output logic [DATA_W-1:0]           rsp_data,
  output logic                        rsp_parity,
  output logic                        busy,
  output logic [TXN_W-1:0]            txn_count
);

  localparam int unsigned ID_W = $clog2(NUM_REQ);

  state_e              state_q, state_d;
  logic [ID_W-1:0]     last_grant_q, last_grant_d;
  logic [ID_W-1:0]     grant_id_q, grant_id_d;
  logic [ID_W-1:0]     rsp_id_q, rsp_id_d;
  logic [DATA_W-1:0]   cap_data_q, cap_data_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic                rsp_parity_q, rsp_parity_d;
  logic                rsp_valid_q, busy_q;
  logic [TXN_W-1:0]    txn_count_q, txn_count_d;
  logic [NUM_REQ-1:0]  req_ready_c;
  logic [ID_W-1:0]     pick_id_c;
  logic                pick_vld_c;
  logic                parity_c;

  parity_unit #(.DATA_W(DATA_W)) u_parity (
    .data_i   (cap_data_q),
    .parity_o (parity_c)
  );

  // Round-robin pick: first valid requester after the last completed grant.
  always_comb begin
    pick_vld_c = 1'b0;
    pick_id_c  = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      if (!pick_vld_c && req_valid[ID_W'((32'(last_grant_q) + k) % NUM_REQ)]) begin
        pick_vld_c = 1'b1;
        pick_id_c  = ID_W'((32'(last_grant_q) + k) % NUM_REQ);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (pick_vld_c) state_d = ST_COMPUTE;
      ST_COMPUTE: state_d = ST_RESPOND;
      ST_RESPOND: if (rsp_ready) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Grant strobe, capture, response load and completion bookkeeping.
  always_comb begin
    req_ready_c  = '0;
    last_grant_d = last_grant_q;
    grant_id_d   = grant_id_q;
    cap_data_d   = cap_data_q;
    rsp_id_d     = rsp_id_q;
    rsp_data_d   = rsp_data_q;
    rsp_parity_d = rsp_parity_q;
    txn_count_d  = txn_count_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_vld_c) begin
          req_ready_c[pick_id_c] = 1'b1;
          grant_id_d             = pick_id_c;
          cap_data_d             = req_data[32'(pick_id_c)*DATA_W +: DATA_W];
        end
      end
      ST_COMPUTE: begin
        rsp_id_d     = grant_id_q;
        rsp_data_d   = cap_data_q;
        rsp_parity_d = parity_c;
      end
      ST_RESPOND: begin
        if (rsp_ready) begin
          last_grant_d = rsp_id_q;
          txn_count_d  = txn_count_q + TXN_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= ID_W'(NUM_REQ - 1);
      grant_id_q   <= '0;
      cap_data_q   <= '0;
      rsp_id_q     <= '0;
      rsp_data_q   <= '0;
      rsp_parity_q <= 1'b0;
      rsp_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      txn_count_q  <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      grant_id_q   <= grant_id_d;
      cap_data_q   <= cap_data_d;
      rsp_id_q     <= rsp_id_d;
      rsp_data_q   <= rsp_data_d;
      rsp_parity_q <= rsp_parity_d;
      rsp_valid_q  <= (state_d == ST_RESPOND);
      busy_q       <= (state_d != ST_IDLE);
      txn_count_q  <= txn_count_d;
    end
  end

  // The grant strobe is combinational, so it is also held low while in reset.
  assign req_ready  = req_ready_c & {NUM_REQ{rst_n}};
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_parity = rsp_parity_q;
  assign busy       = busy_q;
  assign txn_count  = txn_count_q;

endmodule

// File: tb/tb_parity_arbiter.sv
// Self-checking bench for parity_arbiter: directed vector table, corner sequences,
// and randomized traffic against a transaction-level reference model.
module tb_parity_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [1:0]     rsp_id;
  logic [W-1:0]   rsp_data;
  logic           rsp_parity;
  logic           busy;
  logic [15:0]    txn_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [N-1:0]   rv;
    logic [N*W-1:0] rd;
    logic           rr;
    logic [N-1:0]   ready;
    logic           vld;
    logic           bsy;
    logic [1:0]     id;
    logic [W-1:0]   data;
    logic           par;
    logic [15:0]    txn;
  } vec_t;

  vec_t tbl [13];

  // Reference model state: one in-flight transaction described by its age.
  int          m_last, m_txn, m_age, m_id;
  bit          m_inflight;
  logic [7:0]  m_data;
  int          s_id;
  logic [7:0]  s_data;
  int          s_par;

  parity_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .rsp_parity (rsp_parity),
    .busy       (busy),
    .txn_count  (txn_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int gc, last_cyc, gid;
    int exp_ids [5];
    bit saw2;
    logic [N-1:0] exp_ready;
    int g;

    exp_ids = '{0, 1, 2, 3, 0};

    //            rv       rd            rr    ready    vld   bsy   id    data   par   txn
    tbl[0]  = '{4'b0001, 32'h000000A5, 1'b1, 4'b0001, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 16'd0};
    tbl[1]  = '{4'b0000, 32'h00000000, 1'b1, 4'b0000, 1'b0, 1'b1, 2'd0, 8'h00, 1'b0, 16'd0};
    tbl[2]  = '{4'b0000, 32'h00000000, 1'b1, 4'b0000, 1'b1, 1'b1, 2'd0, 8'hA5, 1'b0, 16'd0};
    tbl[3]  = '{4'b0000, 32'h00000000, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 8'hA5, 1'b0, 16'd1};
    tbl[4]  = '{4'b0001, 32'h00000001, 1'b0, 4'b0001, 1'b0, 1'b0, 2'd0, 8'hA5, 1'b0, 16'd1};
    tbl[5]  = '{4'b0000, 32'h00000000, 1'b0, 4'b0000, 1'b0, 1'b1, 2'd0, 8'hA5, 1'b0, 16'd1};
    for (int i = 6; i <= 10; i++)
      tbl[i] = '{4'b0000, 32'h00000000, 1'b0, 4'b0000, 1'b1, 1'b1, 2'd0, 8'h01, 1'b1, 16'd1};
    tbl[11] = '{4'b0010, 32'h00003C00, 1'b1, 4'b0000, 1'b1, 1'b1, 2'd0, 8'h01, 1'b1, 16'd1};
    tbl[12] = '{4'b0010, 32'h00003C00, 1'b0, 4'b0010, 1'b0, 1'b0, 2'd0, 8'h01, 1'b1, 16'd2};

    // Reset values, with requests present to show the grant strobe is held off.
    rst_n     = 1'b0;
    req_valid = 4'b1111;
    req_data  = 32'hDEADBEEF;
    rsp_ready = 1'b1;
    #2;
    chk("rst.req_ready",  32'(req_ready),  32'h0);
    chk("rst.rsp_valid",  32'(rsp_valid),  32'h0);
    chk("rst.busy",       32'(busy),       32'h0);
    chk("rst.rsp_id",     32'(rsp_id),     32'h0);
    chk("rst.rsp_data",   32'(rsp_data),   32'h0);
    chk("rst.rsp_parity", 32'(rsp_parity), 32'h0);
    chk("rst.txn_count",  32'(txn_count),  32'h0);

    // Directed vector table: single transaction, then a 5-cycle stalled response.
    do_reset();
    for (int i = 0; i < 13; i++) begin
      req_valid = tbl[i].rv;
      req_data  = tbl[i].rd;
      rsp_ready = tbl[i].rr;
      #2;
      chk($sformatf("vec%0d.req_ready", i),  32'(req_ready),  32'(tbl[i].ready));
      chk($sformatf("vec%0d.rsp_valid", i),  32'(rsp_valid),  32'(tbl[i].vld));
      chk($sformatf("vec%0d.busy", i),       32'(busy),       32'(tbl[i].bsy));
      chk($sformatf("vec%0d.rsp_id", i),     32'(rsp_id),     32'(tbl[i].id));
      chk($sformatf("vec%0d.rsp_data", i),   32'(rsp_data),   32'(tbl[i].data));
      chk($sformatf("vec%0d.rsp_parity", i), 32'(rsp_parity), 32'(tbl[i].par));
      chk($sformatf("vec%0d.txn_count", i),  32'(txn_count),  32'(tbl[i].txn));
      tick();
    end

    // All requesters held valid: order 0,1,2,3,0 with grants 3 cycles apart.
    do_reset();
    req_valid = 4'b1111;
    req_data  = 32'h44332211;
    rsp_ready = 1'b1;
    gc = 0;
    last_cyc = 0;
    for (int cyc = 0; cyc < 15; cyc++) begin
      #2;
      if (req_ready != '0) begin
        gid = -1;
        for (int j = 0; j < N; j++) if (req_ready[j]) gid = j;
        chk("rr.onehot", 32'($countones(req_ready)), 32'd1);
        if (gc < 5) begin
          chk($sformatf("rr.grant%0d_id", gc), 32'(gid), 32'(exp_ids[gc]));
          chk($sformatf("rr.grant%0d_cycle", gc), 32'(cyc), 32'(gc * 3));
        end
        gc++;
        last_cyc = cyc;
      end
      tick();
    end
    chk("rr.grant_count", 32'(gc), 32'd5);
    chk("rr.last_grant_cycle", 32'(last_cyc), 32'd12);

    // Reset during COMPUTE drops the transaction; next search starts at 0.
    do_reset();
    req_valid = 4'b0100;
    req_data  = 32'h005A0000;
    rsp_ready = 1'b1;
    #2;
    chk("midrst.grant", 32'(req_ready), 32'b0100);
    tick();
    req_valid = 4'b0000;
    #2;
    chk("midrst.busy_before", 32'(busy), 32'h1);
    req_valid = 4'b0100;
    rst_n = 1'b0;
    #1;
    chk("midrst.req_ready",  32'(req_ready),  32'h0);
    chk("midrst.busy",       32'(busy),       32'h0);
    chk("midrst.rsp_valid",  32'(rsp_valid),  32'h0);
    chk("midrst.rsp_data",   32'(rsp_data),   32'h0);
    chk("midrst.txn_count",  32'(txn_count),  32'h0);
    tick();
    rst_n     = 1'b1;
    req_valid = 4'b1001;
    req_data  = 32'h88000077;
    #2;
    chk("midrst.next_grant", 32'(req_ready), 32'b0001);
    chk("midrst.no_rsp",     32'(rsp_valid), 32'h0);
    tick();
    req_valid = 4'b0000;
    tick();
    #2;
    chk("midrst.rsp_valid",  32'(rsp_valid),  32'h1);
    chk("midrst.rsp_id",     32'(rsp_id),     32'h0);
    chk("midrst.rsp_data2",  32'(rsp_data),   32'h77);
    chk("midrst.rsp_parity", 32'(rsp_parity), 32'h0);
    tick();

    // A request dropped before its grant is never served.
    do_reset();
    req_valid = 4'b0001;
    req_data  = 32'h000000C3;
    rsp_ready = 1'b1;
    #2;
    chk("drop.grant0", 32'(req_ready), 32'b0001);
    tick();
    req_valid = 4'b0100;
    req_data  = 32'h00AA0000;
    #2;
    chk("drop.no_ready_busy", 32'(req_ready), 32'h0);
    tick();
    req_valid = 4'b0000;
    saw2 = 1'b0;
    for (int c = 0; c < 8; c++) begin
      #2;
      if (req_ready[2]) saw2 = 1'b1;
      if (rsp_valid && rsp_id == 2'd2) saw2 = 1'b1;
      tick();
    end
    chk("drop.req2_served", 32'(saw2), 32'h0);
    chk("drop.txn_count", 32'(txn_count), 32'd1);

    // Counter wrap from 0xFFFF.
    do_reset();
    force dut.txn_count_q = 16'hFFFF;
    #2;
    release dut.txn_count_q;
    tick();
    req_valid = 4'b0001;
    req_data  = 32'h0000005C;
    rsp_ready = 1'b1;
    #2;
    chk("wrap.grant", 32'(req_ready), 32'b0001);
    tick();
    req_valid = 4'b0000;
    tick();
    tick();
    #2;
    chk("wrap.txn_count", 32'(txn_count), 32'h0000);
    chk("wrap.idle", 32'(busy), 32'h0);

    // Randomized traffic against the transaction-level model.
    do_reset();
    m_last = N - 1; m_txn = 0; m_inflight = 1'b0; m_age = 0; m_id = 0; m_data = '0;
    s_id = 0; s_data = '0; s_par = 0;
    req_valid = '0;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 3) == 0) req_valid = 4'($urandom_range(0, 15));
      req_data  = $urandom();
      rsp_ready = ($urandom_range(0, 3) != 0);
      #2;
      exp_ready = '0;
      g = -1;
      if (!m_inflight) begin
        for (int k = 1; k <= N; k++)
          if (g < 0 && req_valid[(m_last + k) % N]) g = (m_last + k) % N;
        if (g >= 0) exp_ready[g] = 1'b1;
      end
      chk("rnd.req_ready",  32'(req_ready),  32'(exp_ready));
      chk("rnd.rsp_valid",  32'(rsp_valid),  32'(m_inflight && m_age == 2));
      chk("rnd.busy",       32'(busy),       32'(m_inflight));
      chk("rnd.rsp_id",     32'(rsp_id),     32'(s_id));
      chk("rnd.rsp_data",   32'(rsp_data),   32'(s_data));
      chk("rnd.rsp_parity", 32'(rsp_parity), 32'(s_par));
      chk("rnd.txn_count",  32'(txn_count),  32'(m_txn));
      if (!m_inflight && g >= 0) begin
        m_inflight = 1'b1;
        m_age      = 1;
        m_id       = g;
        m_data     = req_data[g*W +: W];
      end else if (m_inflight && m_age == 1) begin
        m_age  = 2;
        s_id   = m_id;
        s_data = m_data;
        s_par  = $countones(m_data) % 2;
      end else if (m_inflight && rsp_ready) begin
        m_last     = m_id;
        m_txn      = (m_txn + 1) % 65536;
        m_inflight = 1'b0;
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
